// File: rtl/cpu_pkg.sv
// Shared CPU definitions: cpustate encodings, default widths, memory region
// constants and the memory bus controller FSM state encoding.
package cpu_pkg;

   // cpustate mode codes
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_IN    = 2'b01;
   localparam logic [1:0] ST_CHECK = 2'b10;
   localparam logic [1:0] ST_RUN   = 2'b11;

   // Default bus widths and memory regions
   localparam int unsigned AW_DEF        = 16;
   localparam int unsigned DW_DEF        = 8;
   localparam int unsigned ROM_WORDS_DEF = 32;
   localparam int unsigned RAM_WORDS_DEF = 1024;

   // Memory bus controller FSM
   typedef logic [2:0] fsm_state_t;
   localparam fsm_state_t StIdle = 3'd0;
   localparam fsm_state_t StRd1  = 3'd1;
   localparam fsm_state_t StRd2  = 3'd2;
   localparam fsm_state_t StWr   = 3'd3;
   localparam fsm_state_t StDone = 3'd4;
   localparam fsm_state_t StErr  = 3'd5;

endpackage

// File: rtl/mem_addr_chk.sv
// Combinational legality decode for a CPU memory access.
// The upper address bits (above the ROM word offset) form the region index:
// index 0 is the read-only ROM, indices below RAM_WORDS are RAM, the rest is
// unmapped.
module mem_addr_chk #(
   parameter int unsigned AW        = 16,
   parameter int unsigned ROM_WORDS = 32,
   parameter int unsigned RAM_WORDS = 1024
) (
   input  logic [AW-1:0] addr_i,
   input  logic          we_i,
   output logic          illegal_o
);

   localparam int unsigned OffW = $clog2(ROM_WORDS);

   logic [AW-OffW-1:0] idx;
   logic [31:0]        idx_ext;
   logic               is_rom;
   logic               out_of_range;

   assign idx     = addr_i[AW-1:OffW];
   assign idx_ext = 32'(idx);

   // Region decode and rejection rules
   always_comb begin
      is_rom       = (idx == '0);
      out_of_range = !is_rom && (idx_ext >= RAM_WORDS);
      illegal_o    = (we_i && is_rom) || out_of_range;
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory access controller between the CPU datapath and the ram block.
// One request at a time over a req/ack handshake; reads take two strobe
// cycles to cover the ram's registered ROM read.
// Optional: define MEM_BUS_CNT_EN to add rd_cnt/wr_cnt/err_cnt statistics.
module mem_bus_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned AW        = AW_DEF,
   parameter int unsigned DW        = DW_DEF,
   parameter int unsigned ROM_WORDS = ROM_WORDS_DEF,
   parameter int unsigned RAM_WORDS = RAM_WORDS_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    cpustate,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic          cpu_err,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
`ifdef MEM_BUS_CNT_EN
   ,
   output logic [15:0]   rd_cnt,
   output logic [15:0]   wr_cnt,
   output logic [7:0]    err_cnt
`endif
);

   fsm_state_t    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          illegal;
   logic          accept;

   mem_addr_chk #(
      .AW        (AW),
      .ROM_WORDS (ROM_WORDS),
      .RAM_WORDS (RAM_WORDS)
   ) u_addr_chk (
      .addr_i    (cpu_addr),
      .we_i      (cpu_we),
      .illegal_o (illegal)
   );

   // New work is only taken from IDLE while the CPU is running
   assign accept = (state_q == StIdle) && cpu_req && (cpustate == ST_RUN);

   // Next-state decode; once accepted a transaction always runs to its ack
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (illegal)     state_d = StErr;
               else if (cpu_we) state_d = StWr;
               else             state_d = StRd1;
            end
         end
         StRd1:   state_d = StRd2;
         StRd2:   state_d = StDone;
         StWr:    state_d = StDone;
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state: bus registers load on accept, read data on RD2
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (accept) begin
         addr_d  = cpu_addr;
         wdata_d = cpu_wdata;
      end
      if (state_q == StRd2) begin
         rdata_d = mem_rdata;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decode straight from state so reset clears them on the same edge
   always_comb begin
      mem_read  = (state_q == StRd1) || (state_q == StRd2);
      mem_write = (state_q == StWr);
      cpu_ack   = (state_q == StDone) || (state_q == StErr);
      cpu_err   = (state_q == StErr);
      busy      = (state_q != StIdle);
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      cpu_rdata = rdata_q;
   end

`ifdef MEM_BUS_CNT_EN
   logic        we_q, we_d;
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   // Count completions: rd/wr wrap, err saturates
   always_comb begin
      we_d      = accept ? cpu_we : we_q;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      err_cnt_d = err_cnt_q;
      if (state_q == StDone) begin
         if (we_q) wr_cnt_d = wr_cnt_q + 16'd1;
         else      rd_cnt_d = rd_cnt_q + 16'd1;
      end
      if ((state_q == StErr) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // Statistics registers
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q      <= 1'b0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         we_q      <= we_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign rd_cnt  = rd_cnt_q;
   assign wr_cnt  = wr_cnt_q;
   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl with a small ram model
// (registered read, ROM word 3 = 8'h5A).
module tb_mem_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  cpustate;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        cpu_err;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [7:0]  mem_rdata;
   logic        busy;
`ifdef MEM_BUS_CNT_EN
   logic [15:0] rd_cnt;
   logic [15:0] wr_cnt;
   logic [7:0]  err_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_bus_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .cpustate  (cpustate),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .cpu_err   (cpu_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata),
      .busy      (busy)
`ifdef MEM_BUS_CNT_EN
      ,
      .rd_cnt    (rd_cnt),
      .wr_cnt    (wr_cnt),
      .err_cnt   (err_cnt)
`endif
   );

   // ram model: registered read, write on strobe, ROM word preloaded on reset
   logic [7:0] ram [0:2047];
   always @(posedge clk) begin
      if (reset) begin
         ram[3] <= 8'h5A;
      end else if (mem_write) begin
         ram[mem_addr[10:0]] <= mem_wdata;
      end
      if (mem_read) mem_rdata <= ram[mem_addr[10:0]];
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request from IDLE and follow it to its ack
   task automatic do_txn(input string tag, input logic we, input logic [15:0] addr,
                         input logic [7:0] wd, input int exp_lat, input logic exp_err,
                         input logic [7:0] exp_rd);
      int lat, nrd, nwr, both;
      lat = 0; nrd = 0; nwr = 0; both = 0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      while (!cpu_ack && lat < 20) begin
         tick();
         lat++;
         if (mem_read) nrd++;
         if (mem_write) nwr++;
         if (mem_read && mem_write) both++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_err"}, 32'(cpu_err), 32'(exp_err));
      check({tag, "_rdata"}, 32'(cpu_rdata), 32'(exp_rd));
      check({tag, "_nrd"}, nrd, (!we && !exp_err) ? 2 : 0);
      check({tag, "_nwr"}, nwr, (we && !exp_err) ? 1 : 0);
      check({tag, "_both"}, both, 0);
      cpu_req = 1'b0;
      tick();
      check({tag, "_idle"}, {30'd0, busy, cpu_ack}, 32'd0);
   endtask

   initial begin
      int acks;
      reset = 1'b1; cpustate = 2'b11; cpu_req = 1'b0; cpu_we = 1'b0;
      cpu_addr = '0; cpu_wdata = '0;
      tick(); tick();
      check("rst_outs", {cpu_rdata, cpu_ack, cpu_err, mem_read, mem_write, busy}, 32'd0);
      check("rst_bus", {mem_addr, mem_wdata}, 32'd0);
      reset = 1'b0;
      tick();

      // ROM read, write/readback, ROM write rejected, range edges
      do_txn("rom_rd",  1'b0, 16'h0003, 8'h00, 3, 1'b0, 8'h5A);
      do_txn("wr40",    1'b1, 16'h0040, 8'hC3, 2, 1'b0, 8'h5A);
      check("wr40_bus", {mem_addr, mem_wdata}, {16'h0040, 8'hC3});
      do_txn("rd40",    1'b0, 16'h0040, 8'h00, 3, 1'b0, 8'hC3);
      do_txn("rom_wr",  1'b1, 16'h0010, 8'hEE, 1, 1'b1, 8'hC3);
      do_txn("oor_rd",  1'b0, 16'h8000, 8'h00, 1, 1'b1, 8'hC3);
      do_txn("last_wr", 1'b1, 16'h7FE0, 8'h11, 2, 1'b0, 8'hC3);
      do_txn("last_rd", 1'b0, 16'h7FE0, 8'h00, 3, 1'b0, 8'h11);

      // Not in RUN: request held but never accepted
      cpustate = 2'b01; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0003;
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (cpu_ack || busy) acks++;
      end
      check("gate_noack", acks, 0);
      cpustate = 2'b11;
      do_txn("gate_rd", 1'b0, 16'h0003, 8'h00, 3, 1'b0, 8'h5A);

      // Leaving RUN mid-transaction still completes it
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
      tick();
      cpustate = 2'b00;
      tick(); tick();
      check("midrun_ack", {30'd0, cpu_ack, cpu_err}, 32'd2);
      check("midrun_rdata", 32'(cpu_rdata), 32'hC3);
      cpu_req = 1'b0; cpustate = 2'b11;
      tick();

      // Reset during RD1 aborts without ack
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
      tick();
      check("rd1_strobe", 32'(mem_read), 32'd1);
      reset = 1'b1; cpu_req = 1'b0;
      tick();
      check("abort_outs", {cpu_rdata, cpu_ack, cpu_err, mem_read, mem_write, busy}, 32'd0);
      check("abort_bus", {mem_addr, mem_wdata}, 32'd0);
      reset = 1'b0;
      tick();
      do_txn("post_rst", 1'b0, 16'h0040, 8'h00, 3, 1'b0, 8'hC3);

`ifdef MEM_BUS_CNT_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("cnt_rst", {rd_cnt, wr_cnt[7:0], err_cnt}, 32'd0);
      do_txn("c_rd1", 1'b0, 16'h0003, 8'h00, 3, 1'b0, 8'h5A);
      do_txn("c_wr1", 1'b1, 16'h0050, 8'h77, 2, 1'b0, 8'h5A);
      do_txn("c_rd2", 1'b0, 16'h0050, 8'h00, 3, 1'b0, 8'h77);
      do_txn("c_er1", 1'b1, 16'h0010, 8'h00, 1, 1'b1, 8'h77);
      do_txn("c_wr2", 1'b1, 16'h0060, 8'h88, 2, 1'b0, 8'h77);
      do_txn("c_rd3", 1'b0, 16'h0060, 8'h00, 3, 1'b0, 8'h88);
      check("rd_cnt", 32'(rd_cnt), 32'd3);
      check("wr_cnt", 32'(wr_cnt), 32'd2);
      check("err_cnt", 32'(err_cnt), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
